ps2_keyboard_tx: RTL
====================

Name: ps2_keyboard_tx

Overview:
- Device-side PS/2 keyboard transmitter: the byte source that drives the PS/2 receiver.
- Accepts scan-code bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as an 11-bit PS/2 frame on generated ps2_clk/ps2_data lines, for FPGA keyboard emulation and for closed-loop tests against the receiver.

Parameters:
- CLK_HALF, 8: system cycles per ps2_clk half-period (high or low phase); legal range ≥ 2.
- GAP_CYCLES, 16: idle cycles (clk=1, data=1) enforced after every frame or abort.
- FIFO_AW, 3: FIFO address width; depth = 2^FIFO_AW.

Ports:
- i_clk  in  1  system clock.
- i_clr_n  in  1  reset; asynchronous assert, active-low.
- i_data  in  8  scan-code byte to send.
- i_break  in  1  break-prefix request (see Optional Feature).
- i_valid  in  1  i_data is valid.
- o_ready  out  1  FIFO can accept; equals !full.
- i_host_inhibit  in  1  host holding clock low; 1 = inhibit.
- o_ps2_clk  out  1  generated PS/2 clock.
- o_ps2_data  out  1  PS/2 data line.
- o_busy  out  1  1 whenever state != IDLE.
- o_abort  out  1  one-cycle pulse on a frame abort.
- o_fifo_count  out  FIFO_AW+1  number of entries held.

Behaviour:
- Reset (async, i_clr_n=0): o_ps2_clk=1, o_ps2_data=1, o_busy=0, o_abort=0, o_fifo_count=0, o_ready=1; FIFO pointers 0; state IDLE.
- FIFO:
  - Push when i_valid & o_ready. Entries are 9 bits {break, data}.
  - Read pointer advances only on successful frame completion.
  - Push and pop in the same cycle: count unchanged.
  - Push while full: impossible, since o_ready=0.
  - Pointers wrap modulo 2^FIFO_AW.
- Frame format: bit0 start=0, bits1-8 data LSB-first, bit9 odd parity (~^data), bit10 stop=1.
- Bit timing:
  - Each bit is a HIGH phase (clk=1, data driven to the bit value on its first cycle) of CLK_HALF cycles, then a LOW phase (clk=0, data held) of CLK_HALF cycles.
  - The receiver samples on the falling edge.
  - One frame is 22*CLK_HALF cycles.
- States:
  - IDLE: clk=1, data=1. Go to LOAD when count>0 and i_host_inhibit=0.
  - LOAD (1 cycle): latch the head entry into a shift register, compute parity, bit index=0. Go to HIGH.
  - HIGH: after CLK_HALF cycles go to LOW.
  - LOW: after CLK_HALF cycles, if index=10 pop FIFO and go to GAP; otherwise index+1 and go to HIGH.
  - GAP: clk=1, data=1 for GAP_CYCLES, then IDLE.
  - INHIBIT: clk=1, data=1; wait for i_host_inhibit=0, then GAP.
- Inhibit:
  - Sampled every cycle.
  - Asserted in HIGH/LOW with index ≤ 9: abort next cycle, release lines to 1, pulse o_abort, do not pop, go to INHIBIT. The byte is retransmitted in full afterwards.
  - Asserted during index 10: ignored; the frame completes.
  - Asserted in IDLE: blocks start.
- Counters: the phase counter is sized for CLK_HALF and GAP_CYCLES; the bit index is 4 bits.
- Async reset mid-frame: lines return to 1 immediately and FIFO contents are discarded.

Optional Feature:
- Macro: PS2_TX_BREAK_PREFIX_EN.
- Defined:
  - An entry with break=1 is sent as two back-to-back frames, 0xF0 then data, separated by GAP_CYCLES.
  - The entry is popped only after the second frame completes.
  - An abort during either frame restarts from the 0xF0 frame.
- Undefined: i_break is ignored; the stored break bit is tied 0.

Test Plan:
- CLK_HALF=4, write 0x1C → after LOAD, 11 falling edges 8 cycles apart; data sampled at falling edges 0,0,0,1,1,1,0,0,0,0,1; frame length 88 cycles; count 1→0 at frame end.
- Write 0x00 then 0xFF → parity bits 1 then 1; at least GAP_CYCLES of idle-high between the frames; o_busy=0 only after the final GAP.
- Push 8 bytes 0x01..0x08 while idle-inhibited (FIFO_AW=3) → o_ready=0, count=8; release → bytes emitted in order and o_ready=1 after the first pop.
- Inhibit asserted at the 5th falling edge of 0x5A → o_abort one pulse, lines high, count stays 1; release → full 0x5A frame retransmitted.
- Inhibit asserted during the stop bit → frame completes, no o_abort; next frame waits for release.
- With PS2_TX_BREAK_PREFIX_EN, write 0x1C, i_break=1 → frames 0xF0 then 0x1C; one FIFO entry consumed. Without the macro → only 0x1C.

Source files
------------

// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side transmitter: buffers {break,data} bytes in a 2^FIFO_AW FIFO and sends 11-bit frames (22*CLK_HALF cycles after a 1-cycle LOAD).
// o_ready = !full; define PS2_TX_BREAK_PREFIX_EN to send a 0xF0 frame ahead of entries pushed with i_break=1.
module ps2_keyboard_tx #(
  parameter int CLK_HALF   = 8,
  parameter int GAP_CYCLES = 16,
  parameter int FIFO_AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic [7:0]       i_data,
  input  logic             i_break,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_host_inhibit,
  output logic             o_ps2_clk,
  output logic             o_ps2_data,
  output logic             o_busy,
  output logic             o_abort,
  output logic [FIFO_AW:0] o_fifo_count
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CMAX  = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
  localparam int CW    = $clog2(CMAX);
  localparam logic [CW-1:0]    HALF_LAST = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0]    GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};

`ifdef PS2_TX_BREAK_PREFIX_EN
  localparam logic BRK_EN = 1'b1;
`else
  localparam logic BRK_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_HIGH    = 3'd2;
  localparam logic [2:0] S_LOW     = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_INHIBIT = 3'd5;

  logic [2:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [3:0]         r_idx;
  logic [10:0]        r_shift;
  logic               r_abort;
  logic               r_prefix_done;
  logic [8:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;

  logic       w_push;
  logic       w_pop;
  logic       w_push_brk;
  logic       w_head_brk;
  logic       w_last_frame;
  logic       w_half_end;
  logic       w_abort;
  logic [8:0] w_head;
  logic [7:0] w_tx_byte;

  assign o_ready      = (r_count != FULL_CNT);
  assign w_push       = i_valid & o_ready;
  assign w_push_brk   = i_break & BRK_EN;
  assign w_head       = r_mem[r_rptr];
  assign w_head_brk   = w_head[8] & BRK_EN;
  // A break entry owns two frames; only the data frame retires it.
  assign w_last_frame = !w_head_brk || r_prefix_done;
  assign w_tx_byte    = (w_head_brk && !r_prefix_done) ? 8'hF0 : w_head[7:0];
  assign w_half_end   = (r_cnt == HALF_LAST);
  assign w_abort      = ((r_state == S_HIGH) || (r_state == S_LOW)) && i_host_inhibit && (r_idx <= 4'd9);
  assign w_pop        = (r_state == S_LOW) && w_half_end && (r_idx == 4'd10) && w_last_frame;

  assign o_ps2_clk    = (r_state != S_LOW);
  assign o_ps2_data   = ((r_state == S_HIGH) || (r_state == S_LOW)) ? r_shift[0] : 1'b1;
  assign o_busy       = (r_state != S_IDLE);
  assign o_abort      = r_abort;
  assign o_fifo_count = r_count;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shift       <= '1;
      r_abort       <= 1'b0;
      r_prefix_done <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((r_count != '0) && !i_host_inhibit) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift <= {1'b1, ~^w_tx_byte, w_tx_byte, 1'b0};
          r_idx   <= '0;
          r_cnt   <= '0;
          r_state <= S_HIGH;
        end
        S_HIGH, S_LOW: begin
          if (w_abort) begin
            r_state       <= S_INHIBIT;
            r_abort       <= 1'b1;
            r_prefix_done <= 1'b0;
            r_cnt         <= '0;
          end else if (w_half_end) begin
            r_cnt <= '0;
            if (r_state == S_HIGH) begin
              r_state <= S_LOW;
            end else if (r_idx == 4'd10) begin
              r_state       <= S_GAP;
              r_prefix_done <= !w_last_frame;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_shift <= {1'b1, r_shift[10:1]};
              r_state <= S_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            // Skip the idle cycle when more work is ready so o_busy stays high across a burst.
            r_state <= ((r_count != '0) && !i_host_inhibit) ? S_LOAD : S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_INHIBIT: begin
          if (!i_host_inhibit) begin
            r_cnt   <= '0;
            r_state <= S_GAP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= {w_push_brk, i_data};
  end

endmodule
